// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: MIRI opcodes, de_ctrl bit positions and opcode-class helpers.
// Also provides the codebase-wide `VIRT_ADDR_WIDTH / `INSTR_WIDTH defaults.
`ifndef VIRT_ADDR_WIDTH
`define VIRT_ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
package decode_stage_pkg;
    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_MUL  = 7'h02;
    localparam logic [6:0] OP_LDB  = 7'h10;
    localparam logic [6:0] OP_LDW  = 7'h11;
    localparam logic [6:0] OP_STB  = 7'h12;
    localparam logic [6:0] OP_STW  = 7'h13;
    localparam logic [6:0] OP_MOV  = 7'h14;
    localparam logic [6:0] OP_BEQ  = 7'h30;
    localparam logic [6:0] OP_JUMP = 7'h31;
    localparam logic [6:0] OP_NOP  = 7'h7F;
    localparam int CTRL_REG_WRT   = 5;
    localparam int CTRL_IS_LOAD   = 4;
    localparam int CTRL_IS_STORE  = 3;
    localparam int CTRL_IS_BRANCH = 2;
    localparam int CTRL_IS_BYTE   = 1;
    localparam int CTRL_ILLEGAL   = 0;
    function automatic logic [5:0] decode_ctrl(input logic [6:0] op);
        logic [5:0] c;
        c = '0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_MOV: c[CTRL_REG_WRT] = 1'b1;
            OP_LDB: begin
                c[CTRL_REG_WRT] = 1'b1;
                c[CTRL_IS_LOAD] = 1'b1;
                c[CTRL_IS_BYTE] = 1'b1;
            end
            OP_LDW: begin
                c[CTRL_REG_WRT] = 1'b1;
                c[CTRL_IS_LOAD] = 1'b1;
            end
            OP_STB, OP_STW:  c[CTRL_IS_STORE] = 1'b1;
            OP_BEQ, OP_JUMP: c[CTRL_IS_BRANCH] = 1'b1;
            OP_NOP:          c = '0;
            default:         c[CTRL_ILLEGAL] = 1'b1;
        endcase
        return c;
    endfunction
    // R-type reads src2; stores read their data register (dst field) on port 2
    function automatic logic reads_port2(input logic [6:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_STB, OP_STW};
    endfunction
    function automatic logic is_btype(input logic [6:0] op);
        return op inside {OP_BEQ, OP_JUMP};
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, execute and writeback signals around decode_stage.
interface decode_stage_if #(
    parameter int VIRT_ADDR_WIDTH = `VIRT_ADDR_WIDTH,
    parameter int INSTR_WIDTH     = `INSTR_WIDTH,
    parameter int REG_IDX_WIDTH   = 5,
    parameter int DATA_WIDTH      = 32
);
    logic [INSTR_WIDTH-1:0]     instr_in;
    logic [VIRT_ADDR_WIDTH-1:0] pc_in;
    logic                       instr_valid;
    logic                       branch_hit;
    logic                       ex_stall;
    logic                       ex_is_load;
    logic [REG_IDX_WIDTH-1:0]   ex_dst;
    logic                       wb_wrt_en;
    logic [REG_IDX_WIDTH-1:0]   wb_dst;
    logic [DATA_WIDTH-1:0]      wb_data;
    logic                       stall_fetch;
    logic                       de_valid;
    logic [VIRT_ADDR_WIDTH-1:0] de_pc;
    logic [6:0]                 de_opcode;
    logic [REG_IDX_WIDTH-1:0]   de_dst;
    logic [DATA_WIDTH-1:0]      de_rs1_val;
    logic [DATA_WIDTH-1:0]      de_rs2_val;
    logic [DATA_WIDTH-1:0]      de_imm;
    logic [5:0]                 de_ctrl;
    modport master (
        output instr_in, pc_in, instr_valid, branch_hit, ex_stall, ex_is_load, ex_dst,
               wb_wrt_en, wb_dst, wb_data,
        input  stall_fetch, de_valid, de_pc, de_opcode, de_dst, de_rs1_val, de_rs2_val,
               de_imm, de_ctrl
    );
    modport slave (
        input  instr_in, pc_in, instr_valid, branch_hit, ex_stall, ex_is_load, ex_dst,
               wb_wrt_en, wb_dst, wb_data,
        output stall_fetch, de_valid, de_pc, de_opcode, de_dst, de_rs1_val, de_rs2_val,
               de_imm, de_ctrl
    );
endinterface

// File: rtl/decode_stage_reg_file.sv
// decode_stage_reg_file: 32x32 register file, two async reads, one sync write, r0 fixed at 0.
module decode_stage_reg_file #(
    parameter int REG_IDX_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [REG_IDX_WIDTH-1:0] i_wr_idx,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic [REG_IDX_WIDTH-1:0] i_rd1_idx,
    input  logic [REG_IDX_WIDTH-1:0] i_rd2_idx,
    output logic [DATA_WIDTH-1:0]    o_rd1_data,
    output logic [DATA_WIDTH-1:0]    o_rd2_data
);
    localparam int NUM_REGS = 1 << REG_IDX_WIDTH;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_wr_en && i_wr_idx != '0) begin
            r_regs[i_wr_idx] <= i_wr_data;
        end
    end
    assign o_rd1_data = (i_rd1_idx == '0) ? '0 : r_regs[i_rd1_idx];
    assign o_rd2_data = (i_rd2_idx == '0) ? '0 : r_regs[i_rd2_idx];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIRI F/D + D/E decode with load-use stall and branch flush.
// Define DECODE_WB_BYPASS_EN to forward a same-cycle writeback into the operand reads.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int VIRT_ADDR_WIDTH = `VIRT_ADDR_WIDTH,
    parameter int INSTR_WIDTH     = `INSTR_WIDTH,
    parameter int REG_IDX_WIDTH   = 5,
    parameter int DATA_WIDTH      = 32
) (
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave bus
);
    logic                       r_fd_valid;
    logic [INSTR_WIDTH-1:0]     r_fd_instr;
    logic [VIRT_ADDR_WIDTH-1:0] r_fd_pc;
    logic                       r_de_valid;
    logic [VIRT_ADDR_WIDTH-1:0] r_de_pc;
    logic [6:0]                 r_de_opcode;
    logic [REG_IDX_WIDTH-1:0]   r_de_dst;
    logic [DATA_WIDTH-1:0]      r_de_rs1_val;
    logic [DATA_WIDTH-1:0]      r_de_rs2_val;
    logic [DATA_WIDTH-1:0]      r_de_imm;
    logic [5:0]                 r_de_ctrl;
    logic [6:0]                 w_op;
    logic [REG_IDX_WIDTH-1:0]   w_dst;
    logic [REG_IDX_WIDTH-1:0]   w_src1;
    logic [REG_IDX_WIDTH-1:0]   w_src2;
    logic [REG_IDX_WIDTH-1:0]   w_rd2_idx;
    logic [DATA_WIDTH-1:0]      w_rf_rd1;
    logic [DATA_WIDTH-1:0]      w_rf_rd2;
    logic [DATA_WIDTH-1:0]      w_rs1_val;
    logic [DATA_WIDTH-1:0]      w_rs2_val;
    logic [DATA_WIDTH-1:0]      w_imm;
    logic [5:0]                 w_ctrl;
    logic                       w_hazard;
    logic                       w_issue;
    assign w_op      = r_fd_instr[31:25];
    assign w_dst     = r_fd_instr[24:20];
    assign w_src1    = r_fd_instr[19:15];
    assign w_src2    = r_fd_instr[14:10];
    assign w_ctrl    = decode_ctrl(w_op);
    assign w_rd2_idx = w_ctrl[CTRL_IS_STORE] ? w_dst : w_src2;
    assign w_imm     = is_btype(w_op)
                     ? {{(DATA_WIDTH-20){r_fd_instr[24]}}, r_fd_instr[24:20], r_fd_instr[14:0]}
                     : {{(DATA_WIDTH-15){r_fd_instr[14]}}, r_fd_instr[14:0]};
    assign w_hazard  = r_fd_valid && bus.ex_is_load && (bus.ex_dst != '0) &&
                       (bus.ex_dst == w_src1 || (reads_port2(w_op) && bus.ex_dst == w_rd2_idx));
    assign w_issue   = r_fd_valid && !w_hazard;
    assign bus.stall_fetch = reset && !bus.branch_hit && (bus.ex_stall || w_hazard);
    decode_stage_reg_file #(
        .REG_IDX_WIDTH (REG_IDX_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_reg_file (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (bus.wb_wrt_en),
        .i_wr_idx   (bus.wb_dst),
        .i_wr_data  (bus.wb_data),
        .i_rd1_idx  (w_src1),
        .i_rd2_idx  (w_rd2_idx),
        .o_rd1_data (w_rf_rd1),
        .o_rd2_data (w_rf_rd2)
    );
`ifdef DECODE_WB_BYPASS_EN
    assign w_rs1_val = (bus.wb_wrt_en && bus.wb_dst == w_src1 && w_src1 != '0) ? bus.wb_data : w_rf_rd1;
    assign w_rs2_val = (bus.wb_wrt_en && bus.wb_dst == w_rd2_idx && w_rd2_idx != '0) ? bus.wb_data : w_rf_rd2;
`else
    assign w_rs1_val = w_rf_rd1;
    assign w_rs2_val = w_rf_rd2;
`endif
    // branch flush beats ex_stall, which beats the load-use bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fd_valid   <= 1'b0;
            r_fd_instr   <= '0;
            r_fd_pc      <= '0;
            r_de_valid   <= 1'b0;
            r_de_pc      <= '0;
            r_de_opcode  <= '0;
            r_de_dst     <= '0;
            r_de_rs1_val <= '0;
            r_de_rs2_val <= '0;
            r_de_imm     <= '0;
            r_de_ctrl    <= '0;
        end else if (bus.branch_hit) begin
            r_fd_valid <= 1'b0;
            r_de_valid <= 1'b0;
            r_de_ctrl  <= '0;
        end else if (!bus.ex_stall) begin
            if (!w_hazard) begin
                r_fd_valid <= bus.instr_valid;
                if (bus.instr_valid) begin
                    r_fd_instr <= bus.instr_in;
                    r_fd_pc    <= bus.pc_in;
                end
            end
            r_de_valid   <= w_issue;
            r_de_pc      <= r_fd_pc;
            r_de_opcode  <= w_op;
            r_de_dst     <= w_dst;
            r_de_rs1_val <= w_rs1_val;
            r_de_rs2_val <= w_rs2_val;
            r_de_imm     <= w_imm;
            r_de_ctrl    <= w_issue ? w_ctrl : '0;
        end
    end
    assign bus.de_valid   = r_de_valid;
    assign bus.de_pc      = r_de_pc;
    assign bus.de_opcode  = r_de_opcode;
    assign bus.de_dst     = r_de_dst;
    assign bus.de_rs1_val = r_de_rs1_val;
    assign bus.de_rs2_val = r_de_rs2_val;
    assign bus.de_imm     = r_de_imm;
    assign bus.de_ctrl    = r_de_ctrl;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode fields, load-use stall, ex_stall, branch flush,
// writeback timing and asynchronous reset.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
`ifdef DECODE_WB_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h0000DEAD;
`else
    localparam logic [31:0] BYP_EXP = 32'h00000005;
`endif
    localparam logic [31:0] I_ADD_R2_R1_R3 = 32'h00208C00;
    localparam logic [31:0] I_ADD_R4_R0_R3 = 32'h00400C00;
    localparam logic [31:0] I_LDW          = 32'h2250FFF0;
    localparam logic [31:0] I_LDB          = 32'h20508010;
    localparam logic [31:0] I_STW          = 32'h26308008;
    localparam logic [31:0] I_BEQ          = 32'h61008004;
    localparam logic [31:0] I_ILL          = 32'hAA000000;
    localparam logic [31:0] I_NOP          = 32'hFE000000;
    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask
    task automatic wb(input logic [4:0] idx, input logic [31:0] data);
        bus.wb_wrt_en = 1'b1;
        bus.wb_dst    = idx;
        bus.wb_data   = data;
        tick;
        bus.wb_wrt_en = 1'b0;
    endtask
    task automatic feed(input logic [31:0] ins, input logic [31:0] pc);
        bus.instr_in    = ins;
        bus.pc_in       = pc;
        bus.instr_valid = 1'b1;
        tick;
        bus.instr_valid = 1'b0;
        tick;
    endtask
    initial begin
        reset           = 1'b0;
        bus.instr_in    = '0;
        bus.pc_in       = '0;
        bus.instr_valid = 1'b0;
        bus.branch_hit  = 1'b0;
        bus.ex_stall    = 1'b0;
        bus.ex_is_load  = 1'b0;
        bus.ex_dst      = '0;
        bus.wb_wrt_en   = 1'b0;
        bus.wb_dst      = '0;
        bus.wb_data     = '0;
        #12;
        chk("rst_de_valid", 32'(bus.de_valid), 0);
        chk("rst_stall", 32'(bus.stall_fetch), 0);
        chk("rst_de_ctrl", 32'(bus.de_ctrl), 0);
        chk("rst_de_pc", bus.de_pc, 0);
        reset = 1'b1;
        wb(5'd1, 32'd5);
        wb(5'd3, 32'd7);
        wb(5'd0, 32'h99);
        bus.instr_in    = I_ADD_R2_R1_R3;
        bus.pc_in       = 32'h1000;
        bus.instr_valid = 1'b1;
        tick;
        chk("add_latency_1", 32'(bus.de_valid), 0);
        bus.instr_valid = 1'b0;
        tick;
        chk("add_valid", 32'(bus.de_valid), 1);
        chk("add_pc", bus.de_pc, 32'h1000);
        chk("add_dst", 32'(bus.de_dst), 2);
        chk("add_rs1", bus.de_rs1_val, 5);
        chk("add_rs2", bus.de_rs2_val, 7);
        chk("add_ctrl", 32'(bus.de_ctrl), 'h20);
        tick;
        chk("idle_bubble", 32'(bus.de_valid), 0);
        feed(I_ADD_R4_R0_R3, 32'h1004);
        chk("r0_rs1", bus.de_rs1_val, 0);
        chk("r0_rs2", bus.de_rs2_val, 7);
        chk("r0_dst", 32'(bus.de_dst), 4);
        feed(I_LDW, 32'h1008);
        chk("ldw_imm", bus.de_imm, 32'hFFFFFFF0);
        chk("ldw_ctrl", 32'(bus.de_ctrl), 'h30);
        chk("ldw_rs1", bus.de_rs1_val, 5);
        chk("ldw_opcode", 32'(bus.de_opcode), 'h11);
        feed(I_LDB, 32'h100C);
        chk("ldb_ctrl", 32'(bus.de_ctrl), 'h32);
        chk("ldb_imm", bus.de_imm, 32'h10);
        feed(I_STW, 32'h1010);
        chk("stw_ctrl", 32'(bus.de_ctrl), 'h08);
        chk("stw_data", bus.de_rs2_val, 7);
        chk("stw_imm", bus.de_imm, 8);
        feed(I_BEQ, 32'h1014);
        chk("beq_ctrl", 32'(bus.de_ctrl), 'h04);
        chk("beq_imm", bus.de_imm, 32'hFFF80004);
        feed(I_ILL, 32'h1018);
        chk("ill_ctrl", 32'(bus.de_ctrl), 'h01);
        chk("ill_opcode", 32'(bus.de_opcode), 'h55);
        feed(I_NOP, 32'h101C);
        chk("nop_ctrl", 32'(bus.de_ctrl), 0);
        chk("nop_valid", 32'(bus.de_valid), 1);
        bus.instr_in    = I_ADD_R2_R1_R3;
        bus.pc_in       = 32'h2000;
        bus.instr_valid = 1'b1;
        tick;
        bus.ex_is_load  = 1'b1;
        bus.ex_dst      = 5'd1;
        bus.instr_in    = I_NOP;
        bus.pc_in       = 32'h2004;
        #1;
        chk("haz_stall", 32'(bus.stall_fetch), 1);
        tick;
        chk("haz_bubble", 32'(bus.de_valid), 0);
        bus.ex_is_load = 1'b0;
        #1;
        chk("haz_release", 32'(bus.stall_fetch), 0);
        tick;
        chk("haz_issue_valid", 32'(bus.de_valid), 1);
        chk("haz_issue_pc", bus.de_pc, 32'h2000);
        bus.instr_valid = 1'b0;
        tick;
        chk("haz_next_pc", bus.de_pc, 32'h2004);
        bus.instr_in    = I_ADD_R4_R0_R3;
        bus.pc_in       = 32'h3000;
        bus.instr_valid = 1'b1;
        tick;
        bus.ex_is_load = 1'b1;
        bus.ex_dst     = 5'd0;
        #1;
        chk("haz_r0_none", 32'(bus.stall_fetch), 0);
        bus.ex_dst = 5'd3;
        #1;
        chk("haz_src2", 32'(bus.stall_fetch), 1);
        bus.ex_is_load = 1'b0;
        bus.instr_in   = I_LDW;
        bus.pc_in      = 32'h3004;
        #1;
        tick;
        bus.instr_valid = 1'b0;
        bus.ex_is_load  = 1'b1;
        bus.ex_dst      = 5'd31;
        #1;
        chk("haz_ld_no_src2", 32'(bus.stall_fetch), 0);
        bus.ex_dst   = 5'd1;
        bus.ex_stall = 1'b1;
        #1;
        chk("exstall_stall", 32'(bus.stall_fetch), 1);
        tick;
        chk("exstall_hold_valid", 32'(bus.de_valid), 1);
        chk("exstall_hold_pc", bus.de_pc, 32'h3000);
        bus.ex_stall = 1'b0;
        tick;
        chk("ld_haz_bubble", 32'(bus.de_valid), 0);
        bus.ex_is_load = 1'b0;
        tick;
        chk("ld_issue_pc", bus.de_pc, 32'h3004);
        chk("ld_issue_ctrl", 32'(bus.de_ctrl), 'h30);
        bus.instr_in    = I_ADD_R2_R1_R3;
        bus.pc_in       = 32'h4000;
        bus.instr_valid = 1'b1;
        tick;
        bus.pc_in = 32'h4004;
        tick;
        bus.pc_in      = 32'h4008;
        bus.branch_hit = 1'b1;
        bus.ex_stall   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_dst     = 5'd1;
        #1;
        chk("br_override", 32'(bus.stall_fetch), 0);
        tick;
        chk("br_flush_de", 32'(bus.de_valid), 0);
        bus.branch_hit  = 1'b0;
        bus.ex_stall    = 1'b0;
        bus.ex_is_load  = 1'b0;
        bus.instr_valid = 1'b0;
        tick;
        chk("br_fd_empty", 32'(bus.de_valid), 0);
        feed(I_ADD_R2_R1_R3, 32'h5000);
        chk("br_recover_valid", 32'(bus.de_valid), 1);
        chk("br_recover_pc", bus.de_pc, 32'h5000);
        bus.instr_in    = I_ADD_R2_R1_R3;
        bus.pc_in       = 32'h6000;
        bus.instr_valid = 1'b1;
        tick;
        bus.instr_valid = 1'b0;
        bus.wb_wrt_en   = 1'b1;
        bus.wb_dst      = 5'd1;
        bus.wb_data     = 32'hDEAD;
        tick;
        bus.wb_wrt_en = 1'b0;
        chk("wb_same_cycle", bus.de_rs1_val, BYP_EXP);
        feed(I_ADD_R2_R1_R3, 32'h6004);
        chk("wb_written", bus.de_rs1_val, 32'hDEAD);
        bus.pc_in       = 32'h7000;
        bus.instr_valid = 1'b1;
        tick;
        bus.pc_in = 32'h7004;
        tick;
        bus.instr_valid = 1'b0;
        bus.ex_stall    = 1'b1;
        #1;
        chk("pre_reset_stall", 32'(bus.stall_fetch), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.de_valid), 0);
        chk("async_rst_stall", 32'(bus.stall_fetch), 0);
        bus.ex_stall = 1'b0;
        #1;
        reset = 1'b1;
        feed(I_ADD_R2_R1_R3, 32'h7008);
        chk("post_rst_valid", 32'(bus.de_valid), 1);
        chk("post_rst_rf_clear", bus.de_rs1_val, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
